// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction queue between fetch and the 2-wide decoder.
// Entries leave in program order, always as whole pairs; rollback flushes all.
module fetch_buffer #(
   parameter int DEPTH     = 8,
   parameter int NUM_SUPER = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_SUPER-1:0]       if_valid,
   input  logic [NUM_SUPER-1:0][31:0] if_inst,
   input  logic [NUM_SUPER-1:0][63:0] if_PC,
   input  logic [NUM_SUPER-1:0][63:0] if_NPC,
   input  logic [NUM_SUPER-1:0][63:0] if_target,
   input  logic                       dispatch_en,
   input  logic                       rollback_en,
   output logic                       fb_ready,
   output logic                       fb_valid,
   output logic [NUM_SUPER-1:0][31:0] fb_inst,
   output logic [NUM_SUPER-1:0][63:0] fb_PC,
   output logic [NUM_SUPER-1:0][63:0] fb_NPC,
   output logic [NUM_SUPER-1:0][63:0] fb_target,
   output logic [$clog2(DEPTH):0]     fb_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0] NOOP = 32'h47ff041f;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] npc;
      logic [63:0] target;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [AW-1:0]   tail1;
   logic [CW-1:0]   count;
   logic            push_ok;
   logic            push_one;
   logic            push_two;
   logic            pop;
   logic [1:0]      n_push;
   logic [1:0]      n_pop;

   assign fb_count = count;
   assign fb_ready = (count <= CW'(DEPTH - 2));
   assign fb_valid = (count >= CW'(2)) && !rollback_en && reset;

   assign push_ok  = fb_ready && !rollback_en;
   assign push_one = push_ok && (if_valid == 2'b01);
   assign push_two = push_ok && (if_valid == 2'b11);
   assign pop      = dispatch_en && fb_valid;

   assign tail1  = tail + AW'(1);
   assign n_push = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);
   assign n_pop  = pop ? 2'd2 : 2'd0;

   always_comb begin
      for (int i = 0; i < NUM_SUPER; i++) begin
         fb_inst[i]   = NOOP;
         fb_PC[i]     = '0;
         fb_NPC[i]    = '0;
         fb_target[i] = '0;
         if (fb_valid) begin
            fb_inst[i]   = mem[head + AW'(i)].inst;
            fb_PC[i]     = mem[head + AW'(i)].pc;
            fb_NPC[i]    = mem[head + AW'(i)].npc;
            fb_target[i] = mem[head + AW'(i)].target;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rollback_en) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(n_pop);
         tail  <= tail + AW'(n_push);
         count <= count + CW'(n_push) - CW'(n_pop);
      end
   end

   // payload array is never reset; only slots covered by count are observable
   always_ff @(posedge clock) begin
      if (reset && (push_one || push_two))
         mem[tail] <= '{if_inst[0], if_PC[0], if_NPC[0], if_target[0]};
      if (reset && push_two)
         mem[tail1] <= '{if_inst[1], if_PC[1], if_NPC[1], if_target[1]};
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the fetch stage and the 2-wide decoder.
- Accepts up to 2 fetched instructions per cycle, each with its PC, NPC and predicted target. Presents them in program order as one pair to the decoder.
- Holds the pair until dispatch consumes it. Flushes on rollback (branch mispredict).
- Its outputs form the decoder's input bundle {valid, inst[2], PC[2], NPC[2], target[2]}.

Parameters:
- DEPTH, 8, number of entries; power of 2, ≥4.
- NUM_SUPER, 2, instructions per pair (fixed at 2).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- if_valid  in  2  per-slot push request; slot 0 is older.
- if_inst  in  2x32  fetched instruction words.
- if_PC  in  2x64  instruction PCs.
- if_NPC  in  2x64  fall-through next PCs.
- if_target  in  2x64  predicted next fetch PCs.
- dispatch_en  in  1  decoder/dispatch accepts the presented pair this cycle.
- rollback_en  in  1  flush all entries.
- fb_ready  out  1  at least 2 free entries; fetch may push.
- fb_valid  out  1  a full pair is presented.
- fb_inst  out  2x32  head, head+1 instructions.
- fb_PC  out  2x64  head, head+1 PCs.
- fb_NPC  out  2x64  head, head+1 NPCs.
- fb_target  out  2x64  head, head+1 targets.
- fb_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage:
  - Circular array of DEPTH entries {inst, PC, NPC, target}.
  - head and tail pointers of $clog2(DEPTH) bits; increments wrap modulo DEPTH.
  - count runs 0..DEPTH.
- Reset (reset==0 at posedge):
  - head=tail=count=0.
  - Same cycle: fb_valid=0, fb_count=0, fb_ready=1.
  - Array contents need no reset.
- fb_ready = (DEPTH − count ≥ 2). Combinational from registered count only; pops in the same cycle are not credited.
- Push (fb_ready && !rollback_en):
  - if_valid=2'b01: write slot 0 at tail; tail+=1.
  - if_valid=2'b11: write slot 0 at tail and slot 1 at tail+1; tail+=2.
  - if_valid=2'b10 is illegal. Nothing is written, and the bench must flag it.
  - When !fb_ready, the push is dropped silently. Fetch must hold its request.
- Present:
  - fb_valid = (count ≥ 2) && !rollback_en && reset.
  - fb_* slot i = entry[head+i] (i=0,1, modulo DEPTH), driven combinationally.
  - While fb_valid=0: fb_inst = NOOP (32'h47ff041f) in both slots; fb_PC/NPC/target = 0.
  - An odd single leftover entry waits until its partner arrives. Pairs are never split.
- Pop (dispatch_en && fb_valid): head+=2, count−=2. dispatch_en while !fb_valid is ignored.
- Simultaneous push and pop: count_next = count + pushed − popped. Both pointers update in the same cycle.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 at the earliest (when it completes a pair).
- Full: count=DEPTH−1 or DEPTH → fb_ready=0. Pop still proceeds.
- Empty: count=0 → fb_valid=0.
- Rollback (rollback_en=1):
  - Next state head=tail=count=0.
  - Pushes and pops in that cycle are discarded.
  - fb_valid is forced 0 in that cycle.
  - Priority: reset > rollback > push/pop.
- Wrap-around: a pair may straddle entry DEPTH−1 and entry 0; order is preserved.
- No combinational path from dispatch_en to fb_ready.

Test Plan:
- Reset, then push 2'b11 {PC 0x0, 0x4}: cycle+1 fb_valid=1, fb_PC={0x0,0x4}, fb_count=2. dispatch_en=1 → next cycle fb_valid=0, fb_count=0.
- Push 2'b01 PC 0x10; next cycle push 2'b01 PC 0x14: fb_valid stays 0 after the first push. It becomes 1 after the second, with fb_PC={0x10,0x14}.
- Fill with 4 pairs (DEPTH=8), no dispatch: fb_count=8, fb_ready=0. A further push of PC 0x100 is dropped. After 4 dispatches the PCs emerge in order and 0x100 never appears.
- Wrap: push 3 pairs, pop 3, push 1 pair (PCs 0x40, 0x44) and then 1 more single, so entries sit at 6, 7, 0. Output {0x40,0x44} correct; head wraps to 0.
- Simultaneous push 2'b11 and dispatch at count=4: fb_count remains 4. The next pair presented is the old entries 2 and 3.
- rollback_en with count=6 and a concurrent push and dispatch: fb_valid=0 that cycle. Next cycle fb_count=0, fb_ready=1, and no flushed PCs ever appear. The same flush results from reset=0 driven mid-stream.
